// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with in-order prefetch FIFO and redirect flush.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    input  logic        decode_ready,
    output logic        misalign
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [31:0]      pc_mem_q    [DEPTH];
    logic [31:0]      pc_mem_d    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];
    logic [31:0]      instr_mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic             halted;
    logic             req_fire, resp_fire, push, pop;
    logic [CNT_W:0]   in_use;
    logic [31:0]      redirect_base;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halted_q, halted_d;
    assign halted = halted_q;
`else
    logic unused_redirect_lsbs;
    assign halted               = 1'b0;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

    // Credit check counts buffered words plus in-flight requests, stale ones included.
    always_comb begin
        instr_valid    = (count_q != '0);
        instr          = instr_valid ? instr_mem_q[rd_ptr_q] : NOP;
        pc_out         = instr_valid ? pc_mem_q[rd_ptr_q] : '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign       = halted_q && instr_valid;
`else
        misalign       = 1'b0;
`endif
        in_use         = {1'b0, count_q} + {1'b0, outstanding_q};
        imem_req_valid = !rst && !redirect_valid && !halted && (in_use < DEPTH_C);
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_fire      = imem_resp_valid && (outstanding_q != '0);
        push           = resp_fire && (discard_q == '0) && !redirect_valid;
        pop            = instr_valid && decode_ready && !redirect_valid;
        redirect_base  = {redirect_pc[31:2], 2'b00};
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        pc_mem_d      = pc_mem_q;
        instr_mem_d   = instr_mem_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
        discard_d     = discard_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        halted_d      = halted_q;
`endif
        if (redirect_valid) begin
            fetch_pc_d = redirect_base;
            resp_pc_d  = redirect_base;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // Every request still in flight now returns a stale word.
            discard_d  = outstanding_q - CNT_W'(resp_fire);
`ifdef FETCH_MISALIGN_TRAP_EN
            halted_d   = (redirect_pc[1:0] != 2'b00);
            if (halted_d) begin
                pc_mem_d[0]    = redirect_pc;
                instr_mem_d[0] = NOP;
                wr_ptr_d       = PTR_W'(1);
                count_d        = CNT_W'(1);
            end
`endif
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_fire && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (push) begin
                pc_mem_d[wr_ptr_q]    = resp_pc_q;
                instr_mem_d[wr_ptr_q] = imem_resp_data;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                resp_pc_d             = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            halted_q      <= 1'b0;
`endif
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            pc_mem_q      <= pc_mem_d;
            instr_mem_q   <= instr_mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            halted_q      <= halted_d;
`endif
        end
    end

endmodule
